// File: rtl/ma_stage_gen.sv
// ----------------------------------------------------------------------------
// ma_stage_gen
//
// Memory-access pipeline stage. It sits between ex_stage and wb_stage and:
//   - registers the MA->WB pipeline state (load flag, dest reg, ALU/address
//     result, writeback enable, misalign exception),
//   - aligns store data into byte lanes and builds byte enables,
//   - detects misaligned halfword/word accesses and suppresses them,
//   - routes accesses whose adr[31:30] equals IO_SEL to the IO window,
//   - arbitrates the single 1R1W data RAM between debug, DMA and CPU,
//   - selects and sign/zero-extends the load lane in WB,
//   - holds the extended load result across a pipeline stall.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_ld_ma / cmd_st_ma    load / store present in MA
//   ldst_code_ma             000 B, 001 H, 010 W, 100 BU, 101 HU
//   adr_ma, st_data_ma       effective address and store data from EX
//   rd_adr_ma, wbk_rd_reg_ma destination register and writeback enable
//   stall, rst_pipe          pipeline stall and synchronous flush
//   dbg_*                    debug RAM port (highest priority)
//   dma_*                    DMA RAM port (second priority)
//   io_*                     IO window strobes, addresses and data
//   ma_busy                  CPU access blocked by debug/DMA this cycle
//   *_wb                     registered WB-side outputs
//   ld_data_wb               final register-ready load value
// ----------------------------------------------------------------------------
module ma_stage_gen #(
  parameter int         DADR_W = 12,
  parameter int         DMA_DW = 16,
  parameter logic [1:0] IO_SEL = 2'b11,
  parameter int         IO_AW  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_ld_ma,
  input  logic              cmd_st_ma,
  input  logic [2:0]        ldst_code_ma,
  input  logic [31:0]       adr_ma,
  input  logic [31:0]       st_data_ma,
  input  logic [4:0]        rd_adr_ma,
  input  logic              wbk_rd_reg_ma,
  input  logic              stall,
  input  logic              rst_pipe,
  input  logic              dbg_re,
  input  logic              dbg_we,
  input  logic [DADR_W-1:0] dbg_radr,
  input  logic [DADR_W-1:0] dbg_wadr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  input  logic              dma_re,
  input  logic              dma_we,
  input  logic [DADR_W-1:0] dma_radr,
  input  logic [DADR_W-1:0] dma_wadr,
  input  logic [DMA_DW-1:0] dma_wdata,
  output logic [DMA_DW-1:0] dma_rdata,
  output logic              io_we,
  output logic              io_re,
  output logic [IO_AW-1:0]  io_wadr,
  output logic [IO_AW-1:0]  io_radr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  output logic              ma_busy,
  output logic              cmd_ld_wb,
  output logic [4:0]        rd_adr_wb,
  output logic [31:0]       rd_data_wb,
  output logic              wbk_rd_reg_wb,
  output logic [31:0]       ld_data_wb,
  output logic              misalign_wb
);

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam int RAM_WORDS = 2 ** DADR_W;

  logic              is_h;
  logic              is_w;
  logic              ld_req;
  logic              misalign_ma;
  logic              io_hit;
  logic [31:0]       st_wdata;
  logic [3:0]        st_be;
  logic              cpu_st_ram;
  logic              cpu_ld_ram;
  logic [DADR_W-1:0] cpu_word;

  logic              ram_we;
  logic [DADR_W-1:0] ram_wadr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              ram_re;
  logic [DADR_W-1:0] ram_radr;
  logic [31:0]       ram_q;
  logic [31:0]       mem [0:RAM_WORDS-1];

  logic              io_sel_wb;
  logic [1:0]        ofs_wb;
  logic [2:0]        code_wb;
  logic              stall_q;
  logic              hold_vld;
  logic [31:0]       hold_buf;
  logic [31:0]       ld_src;
  logic [31:0]       ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Upper address bits only matter for IO decode; the rest are aliased away.
  logic              unused_adr;
  assign unused_adr = ^adr_ma;

  // Access decode. A store always wins over a load if both are asserted, so
  // the load request is masked by cmd_st_ma everywhere.
  always_comb begin
    is_h        = (ldst_code_ma == LS_H) || (ldst_code_ma == LS_HU);
    is_w        = (ldst_code_ma == LS_W);
    ld_req      = cmd_ld_ma & ~cmd_st_ma;
    misalign_ma = (cmd_ld_ma | cmd_st_ma) &
                  ((is_h & adr_ma[0]) | (is_w & (adr_ma[1:0] != 2'b00)));
    io_hit      = (adr_ma[31:30] == IO_SEL);
    cpu_word    = adr_ma[DADR_W+1:2];
  end

  // Store alignment: replicate the datum into every lane and let the byte
  // enables pick the lane. Only B/H/W are store codes; anything else leaves
  // the byte enables at zero so nothing is written.
  always_comb begin
    st_wdata = 32'h0;
    st_be    = 4'b0000;
    case (ldst_code_ma)
      LS_B: begin
        st_wdata = {4{st_data_ma[7:0]}};
        st_be    = 4'b0001 << adr_ma[1:0];
      end
      LS_H: begin
        st_wdata = {2{st_data_ma[15:0]}};
        st_be    = adr_ma[1] ? 4'b1100 : 4'b0011;
      end
      LS_W: begin
        st_wdata = st_data_ma;
        st_be    = 4'b1111;
      end
      default: begin
        st_wdata = 32'h0;
        st_be    = 4'b0000;
      end
    endcase
  end

  // CPU requests to RAM and IO. Misaligned accesses produce no strobe at all.
  // Sub-word stores into the IO window are dropped without raising misalign.
  always_comb begin
    cpu_st_ram = cmd_st_ma & ~io_hit & ~misalign_ma & (st_be != 4'b0000);
    cpu_ld_ram = ld_req & ~io_hit & ~misalign_ma;
    io_we      = cmd_st_ma & io_hit & is_w & ~misalign_ma;
    io_re      = ld_req & io_hit & ~misalign_ma;
    io_wadr    = adr_ma[IO_AW+1:2];
    io_radr    = adr_ma[IO_AW+1:2];
    io_wdata   = st_wdata;
  end

  // Write-port arbitration: debug, then DMA, then CPU. Debug and DMA write
  // whole words; DMA data is zero-extended into the word.
  always_comb begin
    ram_we    = 1'b0;
    ram_wadr  = cpu_word;
    ram_wdata = st_wdata;
    ram_be    = st_be;
    if (dbg_we) begin
      ram_we    = 1'b1;
      ram_wadr  = dbg_wadr;
      ram_wdata = dbg_wdata;
      ram_be    = 4'b1111;
    end else if (dma_we) begin
      ram_we    = 1'b1;
      ram_wadr  = dma_wadr;
      ram_wdata = 32'(dma_wdata);
      ram_be    = 4'b1111;
    end else if (cpu_st_ram) begin
      ram_we    = 1'b1;
    end
  end

  // Read-port arbitration with the same priority order as the write port.
  always_comb begin
    ram_re   = 1'b0;
    ram_radr = cpu_word;
    if (dbg_re) begin
      ram_re   = 1'b1;
      ram_radr = dbg_radr;
    end else if (dma_re) begin
      ram_re   = 1'b1;
      ram_radr = dma_radr;
    end else if (cpu_ld_ram) begin
      ram_re   = 1'b1;
    end
  end

  // The CPU is told to stall whenever it wanted a port that a higher
  // priority master took this cycle; its access simply did not happen.
  assign ma_busy = (cpu_ld_ram & (dbg_re | dma_re)) |
                   (cpu_st_ram & (dbg_we | dma_we));

  // RAM array with per-byte write enables. Contents are never reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) begin
          mem[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered RAM read data (one-cycle latency). It keeps its last value
  // when no master reads, so debug/DMA see their data in the WB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_q <= 32'h0;
    end else if (ram_re) begin
      ram_q <= mem[ram_radr];
    end
  end

  assign dbg_rdata = ram_q;
  assign dma_rdata = ram_q[DMA_DW-1:0];

  // MA->WB pipeline register. Flush beats stall; stall freezes everything,
  // including the IO-source flag and lane/extension info for the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ld_wb     <= 1'b0;
      rd_adr_wb     <= 5'd0;
      rd_data_wb    <= 32'h0;
      wbk_rd_reg_wb <= 1'b0;
      misalign_wb   <= 1'b0;
      io_sel_wb     <= 1'b0;
      ofs_wb        <= 2'b00;
      code_wb       <= 3'b000;
    end else if (rst_pipe) begin
      cmd_ld_wb     <= 1'b0;
      rd_adr_wb     <= 5'd0;
      rd_data_wb    <= 32'h0;
      wbk_rd_reg_wb <= 1'b0;
      misalign_wb   <= 1'b0;
      io_sel_wb     <= 1'b0;
      ofs_wb        <= 2'b00;
      code_wb       <= 3'b000;
    end else if (!stall) begin
      cmd_ld_wb     <= ld_req;
      rd_adr_wb     <= rd_adr_ma;
      rd_data_wb    <= adr_ma;
      wbk_rd_reg_wb <= wbk_rd_reg_ma;
      misalign_wb   <= misalign_ma;
      io_sel_wb     <= io_re;
      ofs_wb        <= adr_ma[1:0];
      code_wb       <= ldst_code_ma;
    end
  end

  // Load lane selection and extension, done on the WB side so the RAM/IO
  // read data can come straight out of its register.
  always_comb begin
    ld_src  = io_sel_wb ? io_rdata : ram_q;
    ld_byte = ld_src[{ofs_wb, 3'b000} +: 8];
    ld_half = ld_src[{ofs_wb[1], 4'b0000} +: 16];
    ld_ext  = 32'h0;
    case (code_wb)
      LS_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LS_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      LS_W:    ld_ext = ld_src;
      LS_BU:   ld_ext = {24'h0, ld_byte};
      LS_HU:   ld_ext = {16'h0, ld_half};
      default: ld_ext = 32'h0;
    endcase
  end

  // Load hold buffer. On the first stall cycle with a load in WB the RAM
  // output is still the load's data, so it is captured then; from the next
  // cycle on the RAM read port may be reused and the buffer is shown
  // instead. The stall edge comes from a locally registered copy of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= 1'b0;
      hold_vld <= 1'b0;
      hold_buf <= 32'h0;
    end else begin
      stall_q <= stall;
      if (rst_pipe) begin
        hold_vld <= 1'b0;
        hold_buf <= 32'h0;
      end else if (!stall) begin
        hold_vld <= 1'b0;
      end else if (!stall_q && cmd_ld_wb) begin
        hold_vld <= 1'b1;
        hold_buf <= ld_ext;
      end
    end
  end

  assign ld_data_wb = hold_vld ? hold_buf : ld_ext;

endmodule

// File: tb/tb_ma_stage_gen.sv
// ----------------------------------------------------------------------------
// tb_ma_stage_gen
//
// Self-checking bench for ma_stage_gen. Loads are pushed onto a scoreboard
// queue with their expected WB values when driven into MA and popped when
// cmd_ld_wb appears after an unstalled edge. Expected load data comes from a
// byte-addressed model of the data RAM kept by the bench.
// ----------------------------------------------------------------------------
module tb_ma_stage_gen;

  localparam int DADR_W = 12;
  localparam int DMA_DW = 16;
  localparam int IO_AW  = 14;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [31:0] IO_RDATA = 32'h8765_4321;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_ld_ma;
  logic              cmd_st_ma;
  logic [2:0]        ldst_code_ma;
  logic [31:0]       adr_ma;
  logic [31:0]       st_data_ma;
  logic [4:0]        rd_adr_ma;
  logic              wbk_rd_reg_ma;
  logic              stall;
  logic              rst_pipe;
  logic              dbg_re;
  logic              dbg_we;
  logic [DADR_W-1:0] dbg_radr;
  logic [DADR_W-1:0] dbg_wadr;
  logic [31:0]       dbg_wdata;
  logic [31:0]       dbg_rdata;
  logic              dma_re;
  logic              dma_we;
  logic [DADR_W-1:0] dma_radr;
  logic [DADR_W-1:0] dma_wadr;
  logic [DMA_DW-1:0] dma_wdata;
  logic [DMA_DW-1:0] dma_rdata;
  logic              io_we;
  logic              io_re;
  logic [IO_AW-1:0]  io_wadr;
  logic [IO_AW-1:0]  io_radr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic              ma_busy;
  logic              cmd_ld_wb;
  logic [4:0]        rd_adr_wb;
  logic [31:0]       rd_data_wb;
  logic              wbk_rd_reg_wb;
  logic [31:0]       ld_data_wb;
  logic              misalign_wb;

  typedef struct {
    logic [31:0] data;
    bit          care;
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] adr;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_m [0:16383];
  int          checks   = 0;
  int          failures = 0;
  logic        stall_at_edge;

  always #5 clk = ~clk;

  ma_stage_gen #(
    .DADR_W(DADR_W), .DMA_DW(DMA_DW), .IO_SEL(2'b11), .IO_AW(IO_AW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .ldst_code_ma(ldst_code_ma),
    .adr_ma(adr_ma), .st_data_ma(st_data_ma), .rd_adr_ma(rd_adr_ma),
    .wbk_rd_reg_ma(wbk_rd_reg_ma), .stall(stall), .rst_pipe(rst_pipe),
    .dbg_re(dbg_re), .dbg_we(dbg_we), .dbg_radr(dbg_radr), .dbg_wadr(dbg_wadr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .dma_re(dma_re), .dma_we(dma_we), .dma_radr(dma_radr), .dma_wadr(dma_wadr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .io_we(io_we), .io_re(io_re), .io_wadr(io_wadr), .io_radr(io_radr),
    .io_wdata(io_wdata), .io_rdata(io_rdata),
    .ma_busy(ma_busy), .cmd_ld_wb(cmd_ld_wb), .rd_adr_wb(rd_adr_wb),
    .rd_data_wb(rd_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
    .ld_data_wb(ld_data_wb), .misalign_wb(misalign_wb)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] modelWord(input logic [31:0] adr);
    int a;
    a = int'({adr[13:2], 2'b00});
    return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] code, input logic [31:0] w,
                                         input logic [1:0] ofs);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (8 * int'(ofs));
    b  = sh[7:0];
    sh = w >> (16 * int'(ofs[1]));
    h  = sh[15:0];
    case (code)
      LS_B:    return {{24{b[7]}}, b};
      LS_BU:   return {24'h0, b};
      LS_H:    return {{16{h[15]}}, h};
      LS_HU:   return {16'h0, h};
      LS_W:    return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic idleAll();
    cmd_ld_ma = 0; cmd_st_ma = 0; ldst_code_ma = 3'b000; adr_ma = 32'h0;
    st_data_ma = 32'h0; rd_adr_ma = 5'd0; wbk_rd_reg_ma = 0;
    dbg_re = 0; dbg_we = 0; dbg_radr = '0; dbg_wadr = '0; dbg_wdata = 32'h0;
    dma_re = 0; dma_we = 0; dma_radr = '0; dma_wadr = '0; dma_wdata = '0;
  endtask

  // One clock: edge, settle, then pop the scoreboard if WB took a load.
  task automatic tick();
    exp_t e;
    stall_at_edge = stall;
    @(posedge clk);
    #1;
    if (!stall_at_edge && !rst && cmd_ld_wb) begin
      if (sb.size() == 0) begin
        checkOutput("sb_pending", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        if (e.care) checkOutput($sformatf("ld_data@%08h", e.adr), ld_data_wb, e.data);
        checkOutput($sformatf("misalign@%08h", e.adr), 32'(misalign_wb), 32'(e.mis));
        checkOutput($sformatf("rd_adr@%08h", e.adr), 32'(rd_adr_wb), 32'(e.rd));
        checkOutput($sformatf("rd_data@%08h", e.adr), rd_data_wb, e.adr);
        checkOutput($sformatf("wbk@%08h", e.adr), 32'(wbk_rd_reg_wb), 32'd1);
      end
    end
  endtask

  // Drive one MA access; loads push their expectation, performed RAM stores
  // update the byte model. 'busy' marks an access the bench expects to lose
  // arbitration (its data is not checked and its store is not performed).
  task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] code,
                               input logic [31:0] adr, input logic [31:0] data,
                               input logic [4:0] rd, input bit busy);
    exp_t e;
    bit   mis;
    bit   io;
    int   a;
    cmd_ld_ma = ld; cmd_st_ma = st; ldst_code_ma = code; adr_ma = adr;
    st_data_ma = data; rd_adr_ma = rd; wbk_rd_reg_ma = 1'b1;
    mis = ((code == LS_H || code == LS_HU) && adr[0]) ||
          (code == LS_W && adr[1:0] != 2'b00);
    io  = (adr[31:30] == 2'b11);
    a   = int'(adr[13:0]);
    if (ld && !st) begin
      e.mis  = mis;
      e.care = !mis && !busy;
      e.rd   = rd;
      e.adr  = adr;
      e.data = extend(code, io ? IO_RDATA : modelWord(adr), adr[1:0]);
      sb.push_back(e);
    end
    if (st && !mis && !io && !busy) begin
      case (code)
        LS_B: mem_m[a] = data[7:0];
        LS_H: begin
          mem_m[a & ~1]     = data[7:0];
          mem_m[(a & ~1)+1] = data[15:8];
        end
        LS_W: begin
          for (int i = 0; i < 4; i++) mem_m[(a & ~3)+i] = data[8*i +: 8];
        end
        default: ;
      endcase
    end
  endtask

  task automatic dbgWrite(input logic [DADR_W-1:0] wadr, input logic [31:0] data);
    dbg_we = 1; dbg_wadr = wadr; dbg_wdata = data;
    for (int i = 0; i < 4; i++) mem_m[int'(wadr)*4+i] = data[8*i +: 8];
    tick();
    dbg_we = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; stall = 0; rst_pipe = 0; io_rdata = IO_RDATA;
    idleAll();
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_cmd_ld_wb", 32'(cmd_ld_wb), 32'd0);
    checkOutput("rst_rd_adr_wb", 32'(rd_adr_wb), 32'd0);
    checkOutput("rst_rd_data_wb", rd_data_wb, 32'h0);
    checkOutput("rst_wbk", 32'(wbk_rd_reg_wb), 32'd0);
    checkOutput("rst_ld_data_wb", ld_data_wb, 32'h0);
    checkOutput("rst_misalign", 32'(misalign_wb), 32'd0);
    checkOutput("rst_dbg_rdata", dbg_rdata, 32'h0);
    rst = 0;

    // Seed the words the tests read back.
    dbgWrite(12'h040, 32'h1122_3344);
    dbgWrite(12'h080, 32'h5566_7788);
    dbgWrite(12'h010, 32'hCAFE_F00D);
    dbgWrite(12'h030, 32'hDEAD_BEEF);

    // Byte store then signed/unsigned byte loads and a full-word check.
    applyStimulus(0, 1, LS_B,  32'h0000_0103, 32'h1234_56A5, 5'd0, 0); tick();
    applyStimulus(1, 0, LS_B,  32'h0000_0103, 32'h0, 5'd1, 0); tick();
    applyStimulus(1, 0, LS_BU, 32'h0000_0103, 32'h0, 5'd2, 0); tick();
    applyStimulus(1, 0, LS_W,  32'h0000_0100, 32'h0, 5'd3, 0); tick();

    // Halfword store into the upper lane; lower bytes must be untouched.
    applyStimulus(0, 1, LS_H,  32'h0000_0202, 32'hFFFF_8001, 5'd0, 0); tick();
    applyStimulus(1, 0, LS_H,  32'h0000_0202, 32'h0, 5'd4, 0); tick();
    applyStimulus(1, 0, LS_HU, 32'h0000_0202, 32'h0, 5'd5, 0); tick();
    applyStimulus(1, 0, LS_BU, 32'h0000_0200, 32'h0, 5'd6, 0); tick();
    applyStimulus(1, 0, LS_BU, 32'h0000_0201, 32'h0, 5'd7, 0); tick();
    applyStimulus(1, 0, LS_W,  32'h0000_0200, 32'h0, 5'd8, 0); tick();

    // Misaligned accesses: flagged, no strobes, no RAM write.
    applyStimulus(1, 0, LS_W, 32'h0000_0006, 32'h0, 5'd9, 0); #1;
    checkOutput("mis_lw_io_re", 32'(io_re), 32'd0);
    checkOutput("mis_lw_busy", 32'(ma_busy), 32'd0);
    tick();
    applyStimulus(1, 0, LS_H, 32'h0000_0201, 32'h0, 5'd10, 0); tick();
    applyStimulus(0, 1, LS_W, 32'h0000_0102, 32'hFFFF_FFFF, 5'd0, 0); #1;
    checkOutput("mis_sw_io_we", 32'(io_we), 32'd0);
    tick();
    applyStimulus(0, 1, LS_W, 32'hC000_0012, 32'hFFFF_FFFF, 5'd0, 0); #1;
    checkOutput("mis_io_sw_we", 32'(io_we), 32'd0);
    tick();

    // IO window: aligned word store, dropped byte store, IO loads.
    applyStimulus(0, 1, LS_W, 32'hC000_0010, 32'h0000_1234, 5'd0, 0); #1;
    checkOutput("io_we", 32'(io_we), 32'd1);
    checkOutput("io_wadr", 32'(io_wadr), 32'd4);
    checkOutput("io_wdata", io_wdata, 32'h0000_1234);
    tick();
    applyStimulus(0, 1, LS_B, 32'hC000_0011, 32'h0000_0055, 5'd0, 0); #1;
    checkOutput("io_sb_we", 32'(io_we), 32'd0);
    tick();
    applyStimulus(0, 1, LS_W, 32'hC000_0100, 32'hFFFF_FFFF, 5'd0, 0); tick();
    applyStimulus(1, 0, LS_W, 32'hC000_0020, 32'h0, 5'd11, 0); #1;
    checkOutput("io_re", 32'(io_re), 32'd1);
    checkOutput("io_radr", 32'(io_radr), 32'd8);
    tick();
    applyStimulus(1, 0, LS_B, 32'hC000_0023, 32'h0, 5'd12, 0); tick();

    // RAM untouched by the misaligned and IO stores; aliased address.
    applyStimulus(1, 0, LS_W, 32'h0000_0100, 32'h0, 5'd13, 0); tick();
    applyStimulus(1, 0, LS_W, 32'h0000_4100, 32'h0, 5'd14, 0); tick();

    // DMA read steals the read port; retry returns the word.
    dma_re = 1; dma_radr = 12'h010;
    applyStimulus(1, 0, LS_W, 32'h0000_0040, 32'h0, 5'd15, 1); #1;
    checkOutput("busy_ld", 32'(ma_busy), 32'd1);
    tick();
    dma_re = 0;
    checkOutput("dma_rdata", 32'(dma_rdata), 32'h0000_F00D);
    applyStimulus(1, 0, LS_W, 32'h0000_0040, 32'h0, 5'd16, 0); #1;
    checkOutput("retry_busy", 32'(ma_busy), 32'd0);
    tick();

    // DMA write steals the write port; the CPU store is not performed.
    dma_we = 1; dma_wadr = 12'h020; dma_wdata = 16'hBEEF;
    applyStimulus(0, 1, LS_W, 32'h0000_0080, 32'h1111_1111, 5'd0, 1); #1;
    checkOutput("busy_st", 32'(ma_busy), 32'd1);
    tick();
    dma_we = 0;
    for (int i = 0; i < 4; i++) mem_m[16'h80 + i] = 8'h00;
    mem_m[16'h80] = 8'hEF; mem_m[16'h81] = 8'hBE;
    applyStimulus(1, 0, LS_W, 32'h0000_0080, 32'h0, 5'd17, 0); tick();

    // Hold across a 3-cycle stall while debug reuses the read port.
    applyStimulus(1, 0, LS_W, 32'h0000_00C0, 32'h0, 5'd18, 0); tick();
    idleAll(); stall = 1; dbg_re = 1; dbg_radr = 12'h010; #1;
    checkOutput("hold_first", ld_data_wb, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      dbg_radr = DADR_W'(12'h040 + 12'(i) * 12'h040);
      checkOutput($sformatf("hold_%0d", i), ld_data_wb, 32'hDEAD_BEEF);
      checkOutput($sformatf("hold_ld_wb_%0d", i), 32'(cmd_ld_wb), 32'd1);
    end
    stall = 0; dbg_re = 0; tick();

    // Flush during stall clears WB registers at the next edge.
    applyStimulus(1, 0, LS_W, 32'h0000_0100, 32'h0, 5'd19, 0); tick();
    idleAll(); stall = 1; rst_pipe = 1; tick();
    rst_pipe = 0;
    checkOutput("flush_cmd_ld_wb", 32'(cmd_ld_wb), 32'd0);
    checkOutput("flush_rd_adr_wb", 32'(rd_adr_wb), 32'd0);
    checkOutput("flush_rd_data_wb", rd_data_wb, 32'h0);
    checkOutput("flush_wbk", 32'(wbk_rd_reg_wb), 32'd0);
    stall = 0; tick();

    // Asynchronous reset in the middle of a held stall.
    applyStimulus(1, 0, LS_W, 32'h0000_00C0, 32'h0, 5'd3, 0); tick();
    idleAll(); stall = 1; tick();
    #2 rst = 1; #1;
    checkOutput("arst_ld_data_wb", ld_data_wb, 32'h0);
    checkOutput("arst_cmd_ld_wb", 32'(cmd_ld_wb), 32'd0);
    checkOutput("arst_rd_data_wb", rd_data_wb, 32'h0);
    checkOutput("arst_rd_adr_wb", 32'(rd_adr_wb), 32'd0);
    checkOutput("arst_dbg_rdata", dbg_rdata, 32'h0);
    rst = 0; stall = 0; tick();

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
